pe_seq_ctrl: RTL and testbench

- Sequencer for the 32-lane parallel inner-product PE (512-bit neuron/weight subvectors, 2-bit ctrl, vld_i in, 32-bit result and valid out).
- Per job, streams `num_sub` subvectors from the neuron buffer and weight buffer for each of `num_out` output neurons.
- Drives the PE first/last ctrl bits and writes each inner-product result to the output buffer.
- Sits between the layer-level controller (start/done) and the PE plus its SRAM buffers.

---
 rtl/pe_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - subvector read sequencer and result writer for the 32-lane inner-product PE
// Defining PE_SEQ_PERF_EN adds the perf_cycles / perf_stalls counters.
module pe_seq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_sub,
  input  logic [CNT_W-1:0]  num_out,
  input  logic [ADDR_W-1:0] nbuf_base,
  input  logic [ADDR_W-1:0] wbuf_base,
  input  logic [ADDR_W-1:0] obuf_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              nbuf_re,
  output logic [ADDR_W-1:0] nbuf_addr,
  output logic              wbuf_re,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              pe_vld,
  output logic [1:0]        pe_ctrl,
  input  logic              pe_res_vld,
  input  logic [31:0]       pe_result,
  output logic              obuf_we,
  output logic [ADDR_W-1:0] obuf_addr,
  output logic [31:0]       obuf_wdata
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cfg_num_sub;
  logic [CNT_W-1:0]  cfg_num_out;
  logic [ADDR_W-1:0] cfg_nbuf_base;
  logic [ADDR_W-1:0] cfg_obuf_base;
  logic [ADDR_W-1:0] wptr;
  logic [CNT_W-1:0]  sub_idx;
  logic [CNT_W-1:0]  out_idx;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_cnt_nxt;
  logic [1:0]        iss_ctrl;
  logic              last_sub;

  logic [RD_LAT-1:0] vld_sr;
  logic [1:0]        ctrl_sr [RD_LAT];

  assign last_sub   = (sub_idx == cfg_num_sub - CNT_W'(1));
  assign wr_cnt_nxt = wr_cnt + CNT_W'(pe_res_vld);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cfg_num_sub   <= '0;
      cfg_num_out   <= '0;
      cfg_nbuf_base <= '0;
      cfg_obuf_base <= '0;
      wptr          <= '0;
      sub_idx       <= '0;
      out_idx       <= '0;
      wr_cnt        <= '0;
      iss_ctrl      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      nbuf_re       <= 1'b0;
      nbuf_addr     <= '0;
      wbuf_re       <= 1'b0;
      wbuf_addr     <= '0;
      obuf_we       <= 1'b0;
      obuf_addr     <= '0;
      obuf_wdata    <= '0;
    end else begin
      done     <= 1'b0;
      nbuf_re  <= 1'b0;
      wbuf_re  <= 1'b0;
      iss_ctrl <= 2'b00;
      obuf_we  <= 1'b0;

      // Results are written whenever a job is active; stray results in IDLE are dropped.
      if (state != S_IDLE && pe_res_vld) begin
        obuf_we    <= 1'b1;
        obuf_addr  <= cfg_obuf_base + ADDR_W'(wr_cnt);
        obuf_wdata <= pe_result;
        wr_cnt     <= wr_cnt_nxt;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_num_sub   <= num_sub;
            cfg_num_out   <= num_out;
            cfg_nbuf_base <= nbuf_base;
            cfg_obuf_base <= obuf_base;
            wptr          <= wbuf_base;
            sub_idx       <= '0;
            out_idx       <= '0;
            wr_cnt        <= '0;
            busy          <= 1'b1;
            state         <= (num_sub == '0 || num_out == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            nbuf_re   <= 1'b1;
            wbuf_re   <= 1'b1;
            nbuf_addr <= cfg_nbuf_base + ADDR_W'(sub_idx);
            wbuf_addr <= wptr;
            wptr      <= wptr + ADDR_W'(1);
            iss_ctrl  <= {last_sub, sub_idx == '0};
            if (last_sub) begin
              sub_idx <= '0;
              out_idx <= out_idx + CNT_W'(1);
              if (out_idx == cfg_num_out - CNT_W'(1))
                state <= S_DRAIN;
            end else begin
              sub_idx <= sub_idx + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (wr_cnt_nxt == cfg_num_out)
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline; iss_ctrl is zero on non-issue cycles so pe_ctrl is 00 whenever pe_vld is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++)
        ctrl_sr[i] <= 2'b00;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        ctrl_sr[i] <= ctrl_sr[i-1];
      end
      vld_sr[0]  <= nbuf_re;
      ctrl_sr[0] <= iss_ctrl;
    end
  end

  assign pe_vld  = vld_sr[RD_LAT-1];
  assign pe_ctrl = ctrl_sr[RD_LAT-1];

`ifdef PE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == S_ISSUE && hold)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - directed bench for pe_seq_ctrl at RD_LAT=1 and RD_LAT=3
// Also checks perf counters when PE_SEQ_PERF_EN is defined.
module tb_pe_seq_ctrl;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start1, start3, hold;
  logic [CNT_W-1:0]  num_sub, num_out;
  logic [ADDR_W-1:0] nb, wb, ob;

  logic              busy1, done1, nre1, wre1, vld1, we1;
  logic [ADDR_W-1:0] naddr1, waddr1, oaddr1;
  logic [1:0]        ctrl1;
  logic [31:0]       wdata1;
  logic              rv1 = 1'b0;
  logic [31:0]       res1 = '0;
  logic [31:0]       beats1 = '0;

  logic              busy3, done3, nre3, wre3, vld3, we3;
  logic [ADDR_W-1:0] naddr3, waddr3, oaddr3;
  logic [1:0]        ctrl3;
  logic [31:0]       wdata3;
  logic              rv3 = 1'b0;
  logic [31:0]       res3 = '0;
  logic [31:0]       beats3 = '0;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_cycles1, perf_stalls1, perf_cycles3, perf_stalls3;
`endif

  pe_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_sub(num_sub), .num_out(num_out),
    .nbuf_base(nb), .wbuf_base(wb), .obuf_base(ob), .hold(hold),
    .busy(busy1), .done(done1), .nbuf_re(nre1), .nbuf_addr(naddr1),
    .wbuf_re(wre1), .wbuf_addr(waddr1), .pe_vld(vld1), .pe_ctrl(ctrl1),
    .pe_res_vld(rv1), .pe_result(res1), .obuf_we(we1), .obuf_addr(oaddr1),
    .obuf_wdata(wdata1)
`ifdef PE_SEQ_PERF_EN
    , .perf_cycles(perf_cycles1), .perf_stalls(perf_stalls1)
`endif
  );

  pe_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .num_sub(num_sub), .num_out(num_out),
    .nbuf_base(nb), .wbuf_base(wb), .obuf_base(ob), .hold(hold),
    .busy(busy3), .done(done3), .nbuf_re(nre3), .nbuf_addr(naddr3),
    .wbuf_re(wre3), .wbuf_addr(waddr3), .pe_vld(vld3), .pe_ctrl(ctrl3),
    .pe_res_vld(rv3), .pe_result(res3), .obuf_we(we3), .obuf_addr(oaddr3),
    .obuf_wdata(wdata3)
`ifdef PE_SEQ_PERF_EN
    , .perf_cycles(perf_cycles3), .perf_stalls(perf_stalls3)
`endif
  );

  // PE models: one cycle after the last beat, result = 0xBEEF0000 | beats in that neuron.
  always @(posedge clk) begin
    rv1 <= vld1 & ctrl1[1];
    if (vld1) begin
      beats1 <= ctrl1[0] ? 32'd1 : beats1 + 32'd1;
      res1   <= 32'hBEEF_0000 | (ctrl1[0] ? 32'd1 : beats1 + 32'd1);
    end
  end

  always @(posedge clk) begin
    rv3 <= vld3 & ctrl3[1];
    if (vld3) begin
      beats3 <= ctrl3[0] ? 32'd1 : beats3 + 32'd1;
      res3   <= 32'hBEEF_0000 | (ctrl3[0] ? 32'd1 : beats3 + 32'd1);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                re_c[$], vld_c[$], we_c[$], done_c[$];
  logic [ADDR_W-1:0] na_q[$], wa_q[$], oa_q[$];
  logic [1:0]        ct_q[$];
  logic [31:0]       wd_q[$];
  int                busy_n = 0, bad_ctrl = 0;
  int                re3_c[$], vld3_c[$], we3_c[$];
  logic [31:0]       wd3_q[$];
  int                done3_n = 0;

  always @(negedge clk) begin
    if (nre1) begin re_c.push_back(cyc); na_q.push_back(naddr1); wa_q.push_back(waddr1); end
    if (vld1) begin vld_c.push_back(cyc); ct_q.push_back(ctrl1); end
    if (!vld1 && ctrl1 != 2'b00) bad_ctrl++;
    if (we1) begin we_c.push_back(cyc); oa_q.push_back(oaddr1); wd_q.push_back(wdata1); end
    if (done1) done_c.push_back(cyc);
    if (busy1) busy_n++;
    if (nre3) re3_c.push_back(cyc);
    if (vld3) vld3_c.push_back(cyc);
    if (we3) begin we3_c.push_back(cyc); wd3_q.push_back(wdata3); end
    if (done3) done3_n++;
  end

  int n_checks = 0, n_err = 0;
  int re_b, vld_b, we_b, done_b, busy_b, bad_b, s_cyc;
  logic [1:0] exp_ct [6] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
  logic [1:0] exp_hold_ct [4] = '{2'b01, 2'b00, 2'b00, 2'b10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    re_b = re_c.size(); vld_b = vld_c.size(); we_b = we_c.size();
    done_b = done_c.size(); busy_b = busy_n; bad_b = bad_ctrl;
  endtask

  task automatic start_job1(input int ns, input int no, input logic [ADDR_W-1:0] b_n,
                            input logic [ADDR_W-1:0] b_w, input logic [ADDR_W-1:0] b_o);
    @(posedge clk); #1;
    num_sub = CNT_W'(ns); num_out = CNT_W'(no); nb = b_n; wb = b_w; ob = b_o;
    start1 = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done1();
    int k = 0;
    while (done_c.size() == done_b && k < 400) begin @(posedge clk); k++; end
    check("done_count", done_c.size() - done_b, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    start1 = 0; start3 = 0; hold = 0; num_sub = '0; num_out = '0; nb = '0; wb = '0; ob = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ctl", {25'd0, busy1, done1, nre1, wre1, vld1, ctrl1}, 32'd0);
    check("reset_addr", {8'd0, naddr1, waddr1}, 32'd0);
    check("reset_obuf", {19'd0, we1, oaddr1} | wdata1, 32'd0);

    // Basic 3x2 job
    mark();
    start_job1(3, 2, 12'h000, 12'h100, 12'h200);
    wait_done1();
    check("basic_reads", re_c.size() - re_b, 6);
    for (int i = 0; i < 6; i++) begin
      check("basic_naddr", na_q[re_b+i], i % 3);
      check("basic_waddr", wa_q[re_b+i], 32'h100 + i);
      check("basic_ctrl", ct_q[vld_b+i], exp_ct[i]);
      check("basic_vld_lat", vld_c[vld_b+i] - re_c[re_b+i], 1);
    end
    check("basic_writes", we_c.size() - we_b, 2);
    for (int i = 0; i < 2; i++) begin
      check("basic_oaddr", oa_q[we_b+i], 32'h200 + i);
      check("basic_wdata", wd_q[we_b+i], 32'hBEEF_0003);
    end
    check("basic_we_lat", we_c[we_b+1] - re_c[re_b+5], 3);
    check("basic_done_after_wr", done_c[done_b] - we_c[we_b+1], 1);
    check("basic_busy_cycles", busy_n - busy_b, 10);

    // num_sub=1 job, with a stray start mid-job that must be ignored
    mark();
    start_job1(1, 4, 12'h010, 12'h020, 12'h030);
    start1 = 1'b1; num_out = CNT_W'(7);
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1();
    check("single_reads", re_c.size() - re_b, 4);
    check("single_writes", we_c.size() - we_b, 4);
    for (int i = 0; i < 4; i++) begin
      check("single_ctrl", ct_q[vld_b+i], 2'b11);
      check("single_naddr", na_q[re_b+i], 32'h010);
      check("single_oaddr", oa_q[we_b+i], 32'h030 + i);
      check("single_wdata", wd_q[we_b+i], 32'hBEEF_0001);
    end

    // Hold on the 2nd and 3rd ISSUE cycles
    mark();
    @(posedge clk); #1;
    num_sub = CNT_W'(4); num_out = CNT_W'(1); nb = 12'h050; wb = 12'h060; ob = 12'h070;
    start1 = 1'b1; s_cyc = cyc;
    @(posedge clk); #1 start1 = 1'b0; hold = 1'b0;
    @(posedge clk); #1 hold = 1'b1;
    @(posedge clk); #1 hold = 1'b1;
    @(posedge clk); #1 hold = 1'b0;
    wait_done1();
    check("hold_reads", re_c.size() - re_b, 4);
    check("hold_span", re_c[re_b+3] - re_c[re_b], 5);
    check("hold_vld_gap", vld_c[vld_b+1] - vld_c[vld_b], 3);
    check("hold_gap_ctrl", bad_ctrl - bad_b, 0);
    for (int i = 0; i < 4; i++) begin
      check("hold_ctrl", ct_q[vld_b+i], exp_hold_ct[i]);
      check("hold_naddr", na_q[re_b+i], 32'h050 + i);
    end
    check("hold_writes", we_c.size() - we_b, 1);
    check("hold_wdata", wd_q[we_b], 32'hBEEF_0004);
    check("hold_busy_cycles", busy_n - busy_b, 10);
`ifdef PE_SEQ_PERF_EN
    check("perf_stalls", perf_stalls1, 2);
    check("perf_cycles", perf_cycles1, 10);
`endif

    // Zero-length jobs
    for (int z = 0; z < 2; z++) begin
      mark();
      start_job1(z == 0 ? 3 : 0, z == 0 ? 0 : 3, 12'h0, 12'h0, 12'h0);
      wait_done1();
      check("zero_reads", re_c.size() - re_b, 0);
      check("zero_writes", we_c.size() - we_b, 0);
      check("zero_done_lat", done_c[done_b] - s_cyc, 2);
      check("zero_busy_cycles", busy_n - busy_b, 1);
    end

    // Mid-job reset during a 3x3 job
    mark();
    start_job1(3, 3, 12'h005, 12'h040, 12'h080);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ctl", {25'd0, busy1, done1, nre1, wre1, vld1, ctrl1}, 32'd0);
    check("mrst_addr", {8'd0, naddr1, waddr1}, 32'd0);
    check("mrst_obuf", {19'd0, we1, oaddr1} | wdata1, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_done", done_c.size() - done_b, 0);
    check("mrst_no_writes", we_c.size() - we_b, 0);
    mark();
    start_job1(2, 2, 12'h000, 12'h300, 12'h400);
    wait_done1();
    check("post_rst_reads", re_c.size() - re_b, 4);
    check("post_rst_writes", we_c.size() - we_b, 2);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_oaddr", oa_q[we_b+i], 32'h400 + i);
      check("post_rst_wdata", wd_q[we_b+i], 32'hBEEF_0002);
    end

    // RD_LAT=3 instance
    @(posedge clk); #1;
    num_sub = CNT_W'(2); num_out = CNT_W'(1); nb = 12'h0; wb = 12'h0; ob = 12'h0;
    start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int k = 0; k < 400 && done3_n == 0; k++) @(posedge clk);
    check("lat3_done", done3_n, 1);
    check("lat3_reads", re3_c.size(), 2);
    check("lat3_writes", we3_c.size(), 1);
    check("lat3_vld_lat", vld3_c[0] - re3_c[0], 3);
    check("lat3_we_lat", we3_c[0] - re3_c[1], 5);
    check("lat3_wdata", wd3_q[0], 32'hBEEF_0002);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
